// File: rtl/shift_sum_pkg.sv
// Shared types and default widths for the shift_sum_sequencer slice.
package shift_sum_pkg;

    localparam int NREQ      = 2;
    localparam int DEF_OPW   = 4;
    localparam int DEF_STEPW = 4;
    localparam int DEF_OUTW  = 2 * DEF_OPW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/shift_sum_sequencer_if.sv
// Command and response channels between requesters and the sequencer.
interface shift_sum_sequencer_if
    import shift_sum_pkg::*;
#(
    parameter int OPW   = DEF_OPW,
    parameter int STEPW = DEF_STEPW,
    parameter int OUTW  = DEF_OUTW
) ();

    // Valid/ready: a transfer happens on a rising clk edge where valid and ready
    // are both high; the source may drop valid before that edge without effect.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*OPW-1:0]   req_a;
    logic [NREQ*OPW-1:0]   req_b;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*STEPW-1:0] req_steps;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [OUTW-1:0]       rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_dir, req_steps, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_dir, req_steps, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/shift_sum_sequencer_arbiter.sv
// Two-way round-robin arbiter; a grant is also the accept, so last_grant follows it.
module rr_arbiter2
    import shift_sum_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            arb_en,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant
);

    logic last_grant_q;

    always_comb begin
        grant = '0;
        if (arb_en) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (|grant) begin
            last_grant_q <= grant[1];
        end
    end

endmodule

// File: rtl/shift_sum_sequencer.sv
// Shares one counter + shift_and_sum datapath between two requesters:
// accept, advance the counters N cycles, capture the result, return it tagged.
module shift_sum_sequencer
    import shift_sum_pkg::*;
#(
    parameter int OPW   = DEF_OPW,
    parameter int STEPW = DEF_STEPW,
    parameter int OUTW  = DEF_OUTW
) (
    input  logic                   clk,
    input  logic                   reset,
    shift_sum_sequencer_if.slave   bus,
    output logic [OPW-1:0]         dp_a,
    output logic [OPW-1:0]         dp_b,
    output logic                   dp_up_down,
    output logic                   dp_en,
    input  logic [OUTW-1:0]        dp_out,
    output logic                   busy,
    output state_e                 state_dbg
);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant;
    logic              gidx;
    logic              accept;
    logic              capture;
    logic              rsp_done;
    logic [STEPW-1:0]  steps_sel;
    logic [STEPW-1:0]  rem_q;
    logic [OUTW-1:0]   rsp_data_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .arb_en    (state_q == IDLE),
        .req_valid (bus.req_valid),
        .grant     (grant)
    );

    assign accept    = |grant;
    assign gidx      = grant[1];
    assign steps_sel = gidx ? bus.req_steps[2*STEPW-1:STEPW] : bus.req_steps[STEPW-1:0];

    always_comb begin
        state_d  = state_q;
        dp_en    = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (steps_sel != '0) ? RUN : CAPTURE;
            end
            RUN: begin
                dp_en = 1'b1;
                if (rem_q == STEPW'(1)) state_d = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                // rsp_valid is always high here, so rsp_ready alone completes the handshake.
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dp_a        <= '0;
            dp_b        <= '0;
            dp_up_down  <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dp_a       <= gidx ? bus.req_a[2*OPW-1:OPW] : bus.req_a[OPW-1:0];
                dp_b       <= gidx ? bus.req_b[2*OPW-1:OPW] : bus.req_b[OPW-1:0];
                dp_up_down <= bus.req_dir[gidx];
                rem_q      <= steps_sel;
                rsp_id_q   <= gidx;
            end else if (dp_en) begin
                rem_q <= rem_q - STEPW'(1);
            end
            if (capture) begin
                rsp_data_q  <= dp_out;
                rsp_valid_q <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;

endmodule
